// File: rtl/pipe_hazard_ctrl.sv
// Hazard and stall controller for the 5-stage pipeline: forwarding selects,
// load-use / mul-div stalls, branch flushes, memory freezes and stall counting.
module pipe_hazard_ctrl #(
  parameter int unsigned MD_LATENCY = 32,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_md_op,
  input  logic             id_md_start,
  input  logic [4:0]       ex_rd,
  input  logic             ex_wreg,
  input  logic             ex_m2reg,
  input  logic             ex_branch_taken,
  input  logic [4:0]       mem_rd,
  input  logic             mem_wreg,
  input  logic             mem_req,
  input  logic             dmem_ready,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             pipe_we,
  output logic             md_start,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int unsigned MDC_W = (MD_LATENCY > 2) ? $clog2(MD_LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_t;

  md_state_t        state, state_nxt;
  logic [MDC_W-1:0] md_cnt, md_cnt_nxt;
  logic [CNT_W-1:0] stall_q;
  logic             freeze, load_use, md_hazard;

  assign freeze    = mem_req && !dmem_ready;
  assign load_use  = ex_wreg && ex_m2reg && (ex_rd != 5'd0) &&
                     ((id_use_rs && ex_rd == id_rs) || (id_use_rt && ex_rd == id_rt));
  assign md_hazard = id_md_op && (state != IDLE);
  assign stall_cnt = stall_q;
  assign md_busy   = !clr && (state != IDLE);

  // EX result takes precedence over MEM; loads in EX cannot forward yet.
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (!clr) begin
      if (ex_wreg && !ex_m2reg && ex_rd != 5'd0 && ex_rd == id_rs)
        fwd_a = 2'b10;
      else if (mem_wreg && mem_rd != 5'd0 && mem_rd == id_rs)
        fwd_a = 2'b01;
      if (ex_wreg && !ex_m2reg && ex_rd != 5'd0 && ex_rd == id_rt)
        fwd_b = 2'b10;
      else if (mem_wreg && mem_rd != 5'd0 && mem_rd == id_rt)
        fwd_b = 2'b01;
    end
  end

  always_comb begin
    pc_we       = 1'b1;
    ifid_we     = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    pipe_we     = 1'b1;
    md_start    = 1'b0;
    if (clr) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      pipe_we     = 1'b0;
    end else if (freeze) begin
      pc_we   = 1'b0;
      ifid_we = 1'b0;
      pipe_we = 1'b0;
    end else if (ex_branch_taken) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (load_use || md_hazard) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      idex_bubble = 1'b1;
    end else begin
      md_start = id_md_start && (state == IDLE);
    end
  end

  // Leaves BUSY on the cycle the counter steps to zero, so BUSY spans MD_LATENCY-1 cycles.
  always_comb begin
    state_nxt  = state;
    md_cnt_nxt = md_cnt;
    unique case (state)
      IDLE: if (md_start) begin
        state_nxt  = BUSY;
        md_cnt_nxt = MDC_W'(MD_LATENCY - 1);
      end
      BUSY: if (!freeze) begin
        md_cnt_nxt = md_cnt - MDC_W'(1);
        if (md_cnt == MDC_W'(1)) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state   <= IDLE;
      md_cnt  <= '0;
      stall_q <= '0;
    end else begin
      state  <= state_nxt;
      md_cnt <= md_cnt_nxt;
      if (!pc_we) stall_q <= stall_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed scenarios then random traffic,
// checked against a cycle-level behavioural model.
module tb_pipe_hazard_ctrl;
  localparam int unsigned MDL = 4;
  localparam int unsigned CW  = 8;

  logic clk = 1'b0;
  logic clr = 1'b1;
  logic [4:0] id_rs = '0, id_rt = '0, ex_rd = '0, mem_rd = '0;
  logic id_use_rs = 0, id_use_rt = 0, id_md_op = 0, id_md_start = 0;
  logic ex_wreg = 0, ex_m2reg = 0, ex_branch_taken = 0, mem_wreg = 0;
  logic mem_req = 0, dmem_ready = 1;
  logic [1:0] fwd_a, fwd_b;
  logic pc_we, ifid_we, ifid_flush, idex_bubble, pipe_we, md_start, md_busy;
  logic [CW-1:0] stall_cnt;

  pipe_hazard_ctrl #(.MD_LATENCY(MDL), .CNT_W(CW)) dut (
    .clk(clk), .clr(clr), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
    .id_use_rt(id_use_rt), .id_md_op(id_md_op), .id_md_start(id_md_start),
    .ex_rd(ex_rd), .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg),
    .ex_branch_taken(ex_branch_taken), .mem_rd(mem_rd), .mem_wreg(mem_wreg),
    .mem_req(mem_req), .dmem_ready(dmem_ready), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .pipe_we(pipe_we), .md_start(md_start),
    .md_busy(md_busy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int fa, fb, pc, ifw, fl, bub, pw, mds, mdb, cnt;
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;

  // Model state: cycles of md activity left (0 = idle, 1 = final result cycle).
  int md_left = 0;
  int cnt_m   = 0;

  function automatic int fwd_of(input logic [4:0] src);
    if (ex_wreg && !ex_m2reg && ex_rd != 0 && ex_rd == src) return 2;
    if (mem_wreg && mem_rd != 0 && mem_rd == src) return 1;
    return 0;
  endfunction

  task automatic cyc();
    exp_t e;
    bit frz, lu, stall;
    frz   = mem_req && !dmem_ready;
    lu    = ex_wreg && ex_m2reg && ex_rd != 0 &&
            ((id_use_rs && ex_rd == id_rs) || (id_use_rt && ex_rd == id_rt));
    stall = lu || (id_md_op && md_left != 0);
    e.cnt = cnt_m;
    if (clr) begin
      e.fa = 0; e.fb = 0; e.pc = 0; e.ifw = 0; e.fl = 1; e.bub = 1; e.pw = 0;
      e.mds = 0; e.mdb = 0;
    end else begin
      e.fa = fwd_of(id_rs);
      e.fb = fwd_of(id_rt);
      e.mdb = (md_left != 0);
      e.mds = 0;
      if (frz) begin
        e.pc = 0; e.ifw = 0; e.fl = 0; e.bub = 0; e.pw = 0;
      end else if (ex_branch_taken) begin
        e.pc = 1; e.ifw = 1; e.fl = 1; e.bub = 1; e.pw = 1;
      end else if (stall) begin
        e.pc = 0; e.ifw = 0; e.fl = 0; e.bub = 1; e.pw = 1;
      end else begin
        e.pc = 1; e.ifw = 1; e.fl = 0; e.bub = 0; e.pw = 1;
        e.mds = (id_md_start && md_left == 0);
      end
    end
    q.push_back(e);
    if (clr) begin
      md_left = 0;
      cnt_m   = 0;
    end else begin
      if (md_left == 1) md_left = 0;
      else if (md_left > 1 && !frz) md_left--;
      if (e.mds) md_left = MDL;
      if (e.pc == 0) cnt_m = (cnt_m + 1) % (1 << CW);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("fwd_a", int'(fwd_a), e.fa);
      chk("fwd_b", int'(fwd_b), e.fb);
      chk("pc_we", int'(pc_we), e.pc);
      chk("ifid_we", int'(ifid_we), e.ifw);
      chk("ifid_flush", int'(ifid_flush), e.fl);
      chk("idex_bubble", int'(idex_bubble), e.bub);
      chk("pipe_we", int'(pipe_we), e.pw);
      chk("md_start", int'(md_start), e.mds);
      chk("md_busy", int'(md_busy), e.mdb);
      chk("stall_cnt", int'(stall_cnt), e.cnt);
    end
  end

  task automatic quiet();
    id_rs = '0; id_rt = '0; ex_rd = '0; mem_rd = '0;
    id_use_rs = 0; id_use_rt = 0; id_md_op = 0; id_md_start = 0;
    ex_wreg = 0; ex_m2reg = 0; ex_branch_taken = 0; mem_wreg = 0;
    mem_req = 0; dmem_ready = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wait_cycles;
    quiet();
    clr = 1;
    @(posedge clk); #1;
    cyc();
    clr = 0;

    // Forwarding: EX match, MEM-only match, register zero, double match
    ex_rd = 5; ex_wreg = 1; id_rs = 5; id_use_rs = 1; cyc();
    ex_wreg = 0; mem_rd = 5; mem_wreg = 1; cyc();
    ex_rd = 0; ex_wreg = 1; mem_rd = 0; id_rs = 0; id_rt = 0; cyc();
    ex_rd = 7; mem_rd = 7; id_rs = 7; id_rt = 7; cyc();
    quiet();

    // Load-use stall then release
    ex_wreg = 1; ex_m2reg = 1; ex_rd = 8; id_rt = 8; id_use_rt = 1; cyc();
    quiet(); cyc();

    // Branch wins over load-use
    ex_wreg = 1; ex_m2reg = 1; ex_rd = 8; id_rt = 8; id_use_rt = 1;
    ex_branch_taken = 1; cyc();
    quiet();

    // Memory wait holding a taken branch
    mem_req = 1; dmem_ready = 0; ex_branch_taken = 1;
    repeat (3) cyc();
    dmem_ready = 1; cyc();
    quiet();

    // Mul/div issue, then dependent md op stalls until idle
    id_md_start = 1; id_md_op = 1; cyc();
    id_md_start = 0;
    repeat (6) cyc();
    quiet();

    // Reset while busy
    id_md_start = 1; id_md_op = 1; cyc();
    quiet(); cyc();
    clr = 1; cyc();
    clr = 0; cyc();

    // Long freeze to wrap the stall counter
    mem_req = 1; dmem_ready = 0;
    repeat (300) cyc();
    quiet(); cyc();

    // Random traffic with small register range to provoke matches
    repeat (2000) begin
      id_rs = 5'($urandom_range(0, 7));
      id_rt = 5'($urandom_range(0, 7));
      ex_rd = 5'($urandom_range(0, 7));
      mem_rd = 5'($urandom_range(0, 7));
      id_use_rs = 1'($urandom);
      id_use_rt = 1'($urandom);
      id_md_start = ($urandom_range(0, 5) == 0);
      id_md_op = id_md_start | ($urandom_range(0, 3) == 0);
      ex_wreg = 1'($urandom);
      ex_m2reg = ($urandom_range(0, 3) == 0);
      ex_branch_taken = ($urandom_range(0, 7) == 0);
      mem_wreg = 1'($urandom);
      mem_req = 1'($urandom);
      dmem_ready = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 99) == 0);
      cyc();
    end
    clr = 0;
    quiet();

    wait_cycles = 0;
    while (q.size() > 0 && wait_cycles < 10) begin
      @(posedge clk);
      wait_cycles++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
